// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS multi-cycle control path.
// Contents:
//   - opcode constants for the supported instruction subset
//   - ALU control codes driven on alu_op
//   - sequencer state encoding
//   - select codes for pc_source, alu_src_b and reg_dst
//   - ctrl_t, the packed control word produced each cycle
//   - dispatch_state(), which maps an opcode to the first state after DECODE
// The datapath and the single-cycle decoder import this package too, so the
// codes defined here are the single source of truth for the core.
package mips_ctrl_pkg;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // ALU control codes
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_LUI   = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0011;
  localparam logic [3:0] ALU_LW    = 4'b0100;
  localparam logic [3:0] ALU_SW    = 4'b0101;
  localparam logic [3:0] ALU_BEQ   = 4'b0110;
  localparam logic [3:0] ALU_BNE   = 4'b0111;
  localparam logic [3:0] ALU_FUNCT = 4'b1111;

  // PC source select
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Register file write address select
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_EXEC_I   = 4'd7,
    ST_WB_R     = 4'd8,
    ST_WB_I     = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_HALT     = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_eq;
    logic       pc_write_ne;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic       link;
    logic       illegal;
  } ctrl_t;

  // First state after DECODE for a given opcode; unsupported opcodes halt.
  function automatic state_t dispatch_state(input logic [5:0] op);
    state_t st;
    case (op)
      OP_RTYPE:                      st = ST_EXEC_R;
      OP_ADDI, OP_ORI, OP_LUI,
      OP_ANDI:                       st = ST_EXEC_I;
      OP_LW, OP_SW:                  st = ST_MEM_ADDR;
      OP_BEQ, OP_BNE:                st = ST_BRANCH;
      OP_J, OP_JAL:                  st = ST_JUMP;
      default:                       st = ST_HALT;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-word decoder for the multi-cycle sequencer.
// Ports:
//   state      in   current sequencer state
//   op         in   opcode latched during DECODE
//   mem_ready  in   memory handshake; only gates the FETCH IR/PC loads
//   ctrl       out  datapath control word for this cycle (illegal left 0;
//                   the parent owns the sticky flag and the reset gating)
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCS_ALU;
        // IR and PC load only on the cycle the fetch actually completes.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = (op == OP_LW) ? ALU_LW : ALU_SW;
      end
      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = REGDST_RT;
      end
      ST_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ST_WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = REGDST_RD;
      end
      ST_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        case (op)
          OP_ORI:  ctrl.alu_op = ALU_OR;
          OP_LUI:  ctrl.alu_op = ALU_LUI;
          OP_ANDI: ctrl.alu_op = ALU_AND;
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      ST_WB_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = REGDST_RT;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = SRCB_REGB;
        ctrl.pc_source   = PCS_ALUOUT;
        ctrl.alu_op      = (op == OP_BEQ) ? ALU_BEQ : ALU_BNE;
        ctrl.pc_write_eq = (op == OP_BEQ);
        ctrl.pc_write_ne = (op != OP_BEQ);
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
        if (op == OP_JAL) begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = REGDST_RA;
          ctrl.link      = 1'b1;
        end
      end
      default: begin
        // HALT and any unreachable encoding: every strobe stays low.
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer for the MIPS core. Steps each instruction
// through fetch / decode / execute / memory / write-back, waits on the unified
// memory's ready handshake, and halts on an unsupported opcode.
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   opcode_i                      IR[31:26], sampled only in DECODE
//   mem_ready_i                   memory access completes this cycle
//   pc_write_o/_eq_o/_ne_o        PC load enables (unconditional / zero / not zero)
//   pc_source_o                   PC next-value select
//   ir_write_o                    instruction register load
//   i_or_d_o                      memory address select (PC or ALUOut)
//   mem_read_o, mem_write_o       memory strobes
//   alu_src_a_o, alu_src_b_o      ALU operand selects
//   alu_op_o                      ALU control code
//   reg_write_o, reg_dst_o        register file write enable and address select
//   mem_to_reg_o, link_o          register write-data selects
//   illegal_o                     sticky unsupported-opcode flag
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_eq_o,
  output logic       pc_write_ne_o,
  output logic [1:0] pc_source_o,
  output logic       ir_write_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [3:0] alu_op_o,
  output logic       reg_write_o,
  output logic [1:0] reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       link_o,
  output logic       illegal_o
);

  state_t     state_reg, state_next;
  logic [5:0] op_reg;
  logic       illegal_reg;
  ctrl_t      ctrl_dec;
  ctrl_t      ctrl_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_FETCH;
      op_reg      <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_DECODE) begin
        op_reg <= opcode_i;
      end
      if (state_next == ST_HALT) begin
        illegal_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH:    if (mem_ready_i) state_next = ST_DECODE;
      // Dispatch uses opcode_i directly; op_reg is only valid from the next state.
      ST_DECODE:   state_next = dispatch_state(opcode_i);
      ST_MEM_ADDR: state_next = (op_reg == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (mem_ready_i) state_next = ST_MEM_WB;
      ST_MEM_WR:   if (mem_ready_i) state_next = ST_FETCH;
      ST_EXEC_R:   state_next = ST_WB_R;
      ST_EXEC_I:   state_next = ST_WB_I;
      ST_MEM_WB,
      ST_WB_R,
      ST_WB_I,
      ST_BRANCH,
      ST_JUMP:     state_next = ST_FETCH;
      ST_HALT:     state_next = ST_HALT;
      default:     state_next = ST_HALT;
    endcase
  end

  mc_output_decode u_output_decode (
    .state     (state_reg),
    .op        (op_reg),
    .mem_ready (mem_ready_i),
    .ctrl      (ctrl_dec)
  );

  // Reset overrides everything combinationally so that no PC, IR or register
  // write can escape during the cycle an instruction is abandoned.
  always_comb begin
    ctrl_out         = ctrl_dec;
    ctrl_out.illegal = illegal_reg;
    if (reset) begin
      ctrl_out = '0;
    end
  end

  assign pc_write_o    = ctrl_out.pc_write;
  assign pc_write_eq_o = ctrl_out.pc_write_eq;
  assign pc_write_ne_o = ctrl_out.pc_write_ne;
  assign pc_source_o   = ctrl_out.pc_source;
  assign ir_write_o    = ctrl_out.ir_write;
  assign i_or_d_o      = ctrl_out.i_or_d;
  assign mem_read_o    = ctrl_out.mem_read;
  assign mem_write_o   = ctrl_out.mem_write;
  assign alu_src_a_o   = ctrl_out.alu_src_a;
  assign alu_src_b_o   = ctrl_out.alu_src_b;
  assign alu_op_o      = ctrl_out.alu_op;
  assign reg_write_o   = ctrl_out.reg_write;
  assign reg_dst_o     = ctrl_out.reg_dst;
  assign mem_to_reg_o  = ctrl_out.mem_to_reg;
  assign link_o        = ctrl_out.link;
  assign illegal_o     = ctrl_out.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction is expanded
// into a per-cycle plan (inputs to drive, full output word expected) from the
// phase lists of the instruction classes; the plan is then played against the
// DUT and every cycle's output word is compared. Directed scenarios add
// literal spot checks on the recorded DUT outputs.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode_i;
  logic       mem_ready_i;
  logic       pc_write_o, pc_write_eq_o, pc_write_ne_o;
  logic [1:0] pc_source_o;
  logic       ir_write_o, i_or_d_o, mem_read_o, mem_write_o, alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [3:0] alu_op_o;
  logic       reg_write_o;
  logic [1:0] reg_dst_o;
  logic       mem_to_reg_o, link_o, illegal_o;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk           (clk),
    .reset         (reset),
    .opcode_i      (opcode_i),
    .mem_ready_i   (mem_ready_i),
    .pc_write_o    (pc_write_o),
    .pc_write_eq_o (pc_write_eq_o),
    .pc_write_ne_o (pc_write_ne_o),
    .pc_source_o   (pc_source_o),
    .ir_write_o    (ir_write_o),
    .i_or_d_o      (i_or_d_o),
    .mem_read_o    (mem_read_o),
    .mem_write_o   (mem_write_o),
    .alu_src_a_o   (alu_src_a_o),
    .alu_src_b_o   (alu_src_b_o),
    .alu_op_o      (alu_op_o),
    .reg_write_o   (reg_write_o),
    .reg_dst_o     (reg_dst_o),
    .mem_to_reg_o  (mem_to_reg_o),
    .link_o        (link_o),
    .illegal_o     (illegal_o)
  );

  // Output word layout (bit positions):
  // 21 pc_write, 20 eq, 19 ne, 18:17 pc_source, 16 ir_write, 15 i_or_d,
  // 14 mem_read, 13 mem_write, 12 src_a, 11:10 src_b, 9:6 alu_op,
  // 5 reg_write, 4:3 reg_dst, 2 mem_to_reg, 1 link, 0 illegal
  logic [21:0] act_vec;
  assign act_vec = {pc_write_o, pc_write_eq_o, pc_write_ne_o, pc_source_o,
                    ir_write_o, i_or_d_o, mem_read_o, mem_write_o,
                    alu_src_a_o, alu_src_b_o, alu_op_o, reg_write_o,
                    reg_dst_o, mem_to_reg_o, link_o, illegal_o};

  localparam logic [21:0] B_ILL = 22'd1 << 0;
  localparam logic [21:0] B_LNK = 22'd1 << 1;
  localparam logic [21:0] B_M2R = 22'd1 << 2;
  localparam logic [21:0] B_RW  = 22'd1 << 5;
  localparam logic [21:0] B_SA  = 22'd1 << 12;
  localparam logic [21:0] B_MW  = 22'd1 << 13;
  localparam logic [21:0] B_MR  = 22'd1 << 14;
  localparam logic [21:0] B_IOD = 22'd1 << 15;
  localparam logic [21:0] B_IRW = 22'd1 << 16;
  localparam logic [21:0] B_NE  = 22'd1 << 19;
  localparam logic [21:0] B_EQ  = 22'd1 << 20;
  localparam logic [21:0] B_PCW = 22'd1 << 21;

  function automatic logic [21:0] f_pcs(input int v); return 22'(v) << 17; endfunction
  function automatic logic [21:0] f_sb (input int v); return 22'(v) << 10; endfunction
  function automatic logic [21:0] f_alu(input int v); return 22'(v) << 6;  endfunction
  function automatic logic [21:0] f_rd (input int v); return 22'(v) << 3;  endfunction

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [5:0]  op;
    logic [21:0] exp;
  } step_t;

  step_t       plan[$];
  step_t       tmp[$];
  logic [21:0] act_log[$];
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  task automatic put(input logic rdy, input logic [5:0] op, input logic [21:0] e);
    step_t s;
    s.rst = 1'b0; s.rdy = rdy; s.op = op; s.exp = e;
    tmp.push_back(s);
  endtask

  // A cycle where memory readiness must not matter: drive it randomly.
  task automatic put_idle(input logic [21:0] e);
    put(1'($urandom), rnd_op(), e);
  endtask

  // A memory phase: `waits` stalled cycles, then the completing cycle.
  task automatic put_mem(input logic [21:0] e, input logic [21:0] e_done, input int waits);
    for (int k = 0; k < waits; k++) put(1'b0, rnd_op(), e);
    put(1'b1, rnd_op(), e_done);
  endtask

  task automatic put_reset();
    step_t s;
    s.rst = 1'b1; s.rdy = 1'($urandom); s.op = rnd_op(); s.exp = '0;
    tmp.push_back(s);
  endtask

  // Expand one instruction into its expected cycle sequence.
  task automatic build(input logic [5:0] op, input int fw, input int mw, input int halt_n);
    logic [21:0] fetch_e;
    fetch_e = B_MR | f_sb(1);
    put_mem(fetch_e, fetch_e | B_PCW | B_IRW, fw);
    put(1'($urandom), op, f_sb(3));
    case (op)
      6'h00: begin
        put_idle(B_SA | f_sb(0) | f_alu(15));
        put_idle(B_RW | f_rd(1));
      end
      6'h08, 6'h0d, 6'h0f, 6'h0c: begin
        int a;
        a = (op == 6'h08) ? 0 : (op == 6'h0d) ? 1 : (op == 6'h0f) ? 2 : 3;
        put_idle(B_SA | f_sb(2) | f_alu(a));
        put_idle(B_RW | f_rd(0));
      end
      6'h23: begin
        put_idle(B_SA | f_sb(2) | f_alu(4));
        put_mem(B_MR | B_IOD, B_MR | B_IOD, mw);
        put_idle(B_RW | B_M2R | f_rd(0));
      end
      6'h2b: begin
        put_idle(B_SA | f_sb(2) | f_alu(5));
        put_mem(B_MW | B_IOD, B_MW | B_IOD, mw);
      end
      6'h04: put_idle(B_SA | f_sb(0) | f_alu(6) | f_pcs(1) | B_EQ);
      6'h05: put_idle(B_SA | f_sb(0) | f_alu(7) | f_pcs(1) | B_NE);
      6'h02: put_idle(B_PCW | f_pcs(2));
      6'h03: put_idle(B_PCW | f_pcs(2) | B_RW | f_rd(2) | B_LNK);
      default: begin
        for (int k = 0; k < halt_n; k++) put_idle(B_ILL);
        put_reset();
      end
    endcase
  endtask

  // Move the staged instruction into the plan, optionally abandoning it with
  // a reset at step `cut` (negative = run to completion).
  task automatic commit(input int cut);
    int n;
    n = tmp.size();
    if (cut >= 0 && cut < n) n = cut;
    for (int k = 0; k < n; k++) plan.push_back(tmp[k]);
    if (cut >= 0 && cut < tmp.size()) begin
      tmp.delete();
      put_reset();
      plan.push_back(tmp[0]);
    end
    tmp.delete();
  endtask

  task automatic add_instr(input logic [5:0] op, input int fw, input int mw, input int halt_n, input int cut);
    build(op, fw, mw, halt_n);
    commit(cut);
  endtask

  // Play the plan: drive after the rising edge, compare on the falling edge.
  task automatic run_plan();
    step_t s;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      reset       = s.rst;
      mem_ready_i = s.rdy;
      opcode_i    = s.op;
      @(negedge clk);
      checks++;
      act_log.push_back(act_vec);
      if (act_vec !== s.exp) begin
        failures++;
        $display("FAIL ctrl_word cycle=%0d got=%06h want=%06h", act_log.size() - 1, act_vec, s.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Literal check of one field of a recorded output word.
  task automatic lit(input string name, input int idx, input int lsb, input int width, input int want);
    int a;
    checks++;
    if (idx >= act_log.size()) begin
      failures++;
      $display("FAIL %s no output recorded at cycle %0d", name, idx);
    end else begin
      a = int'((act_log[idx] >> lsb) & ((22'd1 << width) - 22'd1));
      if (a != want) begin
        failures++;
        $display("FAIL %s cycle=%0d got=%0h want=%0h", name, idx, a, want);
      end
    end
  endtask

  localparam logic [5:0] SUPPORTED [11] = '{6'h00, 6'h08, 6'h0d, 6'h0f, 6'h0c,
                                            6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};
  localparam logic [5:0] BAD_OPS [5] = '{6'h3f, 6'h01, 6'h22, 6'h10, 6'h2a};

  initial begin
    int b;
    reset       = 1'b1;
    mem_ready_i = 1'b0;
    opcode_i    = '0;
    @(posedge clk);
    #1;

    // Reset state: everything low while reset is held.
    b = act_log.size();
    for (int k = 0; k < 3; k++) put_reset();
    for (int k = 0; k < 3; k++) plan.push_back(tmp[k]);
    tmp.delete();
    run_plan();
    lit("reset_word", b, 0, 22, 0);

    // ADDI, no memory wait; a following ADDI shows FETCH at cycle 4.
    b = act_log.size();
    add_instr(6'h08, 0, 0, 0, -1);
    add_instr(6'h08, 0, 0, 0, -1);
    run_plan();
    lit("addi_fetch_ir_write", b, 16, 1, 1);
    lit("addi_exec_alu_op", b + 2, 6, 4, 0);
    lit("addi_exec_src_b", b + 2, 10, 2, 2);
    lit("addi_wb_reg_write", b + 3, 5, 1, 1);
    lit("addi_wb_reg_dst", b + 3, 3, 2, 0);
    lit("addi_next_fetch", b + 4, 14, 1, 1);

    // LW with two stalled MEM_RD cycles: 7 cycles total.
    b = act_log.size();
    add_instr(6'h23, 0, 2, 0, -1);
    add_instr(6'h00, 0, 0, 0, -1);
    run_plan();
    for (int k = 3; k <= 5; k++) begin
      lit("lw_mem_read_held", b + k, 14, 1, 1);
      lit("lw_i_or_d_held", b + k, 15, 1, 1);
    end
    lit("lw_mem_to_reg", b + 6, 2, 1, 1);
    lit("lw_next_fetch_addr_pc", b + 7, 15, 1, 0);
    lit("lw_next_fetch_read", b + 7, 14, 1, 1);

    // BNE
    b = act_log.size();
    add_instr(6'h05, 0, 0, 0, -1);
    add_instr(6'h02, 0, 0, 0, -1);
    run_plan();
    lit("bne_pc_write_ne", b + 2, 19, 1, 1);
    lit("bne_pc_write_eq", b + 2, 20, 1, 0);
    lit("bne_pc_source", b + 2, 17, 2, 1);
    lit("bne_alu_op", b + 2, 6, 4, 7);
    lit("bne_next_fetch", b + 3, 14, 1, 1);

    // JAL
    b = act_log.size();
    add_instr(6'h03, 0, 0, 0, -1);
    run_plan();
    lit("jal_pc_write", b + 2, 21, 1, 1);
    lit("jal_pc_source", b + 2, 17, 2, 2);
    lit("jal_reg_write", b + 2, 5, 1, 1);
    lit("jal_reg_dst", b + 2, 3, 2, 2);
    lit("jal_link", b + 2, 1, 1, 1);

    // Unsupported opcode: HALT for 20 cycles, then reset back to FETCH.
    b = act_log.size();
    add_instr(6'h3f, 0, 0, 20, -1);
    add_instr(6'h08, 0, 0, 0, -1);
    run_plan();
    for (int k = 2; k < 22; k++) lit("halt_word", b + k, 0, 22, 1);
    lit("halt_reset_word", b + 22, 0, 22, 0);
    lit("after_halt_illegal", b + 23, 0, 1, 0);
    lit("after_halt_fetch", b + 23, 14, 1, 1);

    // SW abandoned by reset during the MEM_WR wait.
    b = act_log.size();
    add_instr(6'h2b, 0, 3, 0, 5);
    add_instr(6'h00, 0, 0, 0, -1);
    run_plan();
    lit("sw_wait_mem_write", b + 4, 13, 1, 1);
    lit("sw_reset_word", b + 5, 0, 22, 0);
    lit("sw_reset_next_fetch", b + 6, 14, 1, 1);
    // R-type that followed: opcode_i wanders during EXEC_R, alu_op must not.
    lit("rtype_exec_alu_op", b + 8, 6, 4, 15);
    lit("rtype_wb_reg_dst", b + 9, 3, 2, 1);

    // Randomized instruction stream with random waits and random resets.
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      int cut;
      if ($urandom_range(0, 19) == 0) op = BAD_OPS[$urandom_range(0, 4)];
      else                            op = SUPPORTED[$urandom_range(0, 10)];
      cut = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
      add_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 5), cut);
      run_plan();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
